// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: sequences one serial word through an external
// clock generator and assembles the received word.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; mosi holds its last driven value
// RUN   | clock generator running; shifting on tx/rx strobes
// DONE  | single cycle: done pulse, rx_data published
module spi_xfer_ctrl #(
    parameter int SPI_DIVIDER_LEN = 8,
    parameter int SPI_MAX_CHAR    = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [4:0]                 char_len,
    input  logic                       lsb,
    input  logic                       tx_negedge,
    input  logic                       rx_negedge,
    input  logic [SPI_DIVIDER_LEN-1:0] div_in,
    input  logic [SPI_MAX_CHAR-1:0]    tx_data,
    input  logic                       miso,
    input  logic                       cg_pos_edge,
    input  logic                       cg_neg_edge,
    output logic                       cg_enable,
    output logic                       cg_go,
    output logic                       cg_last_clk,
    output logic [SPI_DIVIDER_LEN-1:0] cg_divider,
    output logic                       mosi,
    output logic [SPI_MAX_CHAR-1:0]    rx_data,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(SPI_MAX_CHAR + 1);
    localparam int IDX_W = $clog2(SPI_MAX_CHAR);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(SPI_MAX_CHAR);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CNT_W-1:0]           len_q, len_d;
    logic                       lsb_sel_q, lsb_sel_d;
    logic                       tx_neg_q, tx_neg_d;
    logic                       rx_neg_q, rx_neg_d;
    logic [SPI_MAX_CHAR-1:0]    tx_sr_q, tx_sr_d;
    logic [SPI_MAX_CHAR-1:0]    rx_sr_q, rx_sr_d;
    logic [SPI_MAX_CHAR-1:0]    rx_data_q, rx_data_d;
    logic [SPI_DIVIDER_LEN-1:0] divider_q, divider_d;
    logic                       mosi_q, mosi_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic             tx_edge;
    logic             rx_edge;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] len_in;

    // Edge selects and bit index come from values frozen at start, so
    // reconfiguring the inputs mid-transfer cannot disturb the word.
    assign tx_edge = tx_neg_q ? cg_neg_edge : cg_pos_edge;
    assign rx_edge = rx_neg_q ? cg_neg_edge : cg_pos_edge;
    assign bit_idx = lsb_sel_q ? IDX_W'(len_q - cnt_q) : IDX_W'(cnt_q - ONE);
    assign len_in  = (char_len == 5'd0) ? MAX_LEN : CNT_W'(char_len);

    assign cg_enable   = (state_q != ST_IDLE);
    assign cg_go       = (state_q == ST_RUN);
    assign cg_last_clk = (state_q == ST_RUN) && (cnt_q == ONE);
    assign cg_divider  = divider_q;
    assign mosi        = mosi_q;
    assign rx_data     = rx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next-state and datapath decode; tx uses the pre-decrement count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        lsb_sel_d = lsb_sel_q;
        tx_neg_d  = tx_neg_q;
        rx_neg_d  = rx_neg_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        divider_d = divider_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    busy_d    = 1'b1;
                    tx_sr_d   = tx_data;
                    rx_sr_d   = '0;
                    cnt_d     = len_in;
                    len_d     = len_in;
                    lsb_sel_d = lsb;
                    tx_neg_d  = tx_negedge;
                    rx_neg_d  = rx_negedge;
                    divider_d = div_in;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    if (tx_edge) begin
                        mosi_d = tx_sr_q[bit_idx];
                    end
                    if (rx_edge) begin
                        rx_sr_d[bit_idx] = miso;
                        cnt_d            = cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            for (int i = 0; i < SPI_MAX_CHAR; i++) begin
                                rx_data_d[i] = (i < int'(len_q)) ? rx_sr_d[i] : 1'b0;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            lsb_sel_q <= 1'b0;
            tx_neg_q  <= 1'b0;
            rx_neg_q  <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            divider_q <= '0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            lsb_sel_q <= lsb_sel_d;
            tx_neg_q  <= tx_neg_d;
            rx_neg_q  <= rx_neg_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            divider_q <= divider_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: clock-generator model with optional MISO
// loopback, a word-level reference model, and directed transfers.
module tb_spi_xfer_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start, abort, lsb, tx_negedge, rx_negedge, miso;
    logic [4:0]  char_len;
    logic [7:0]  div_in;
    logic [31:0] tx_data;
    logic        cg_pos_edge, cg_neg_edge;
    logic        cg_enable, cg_go, cg_last_clk, mosi, busy, done;
    logic [7:0]  cg_divider;
    logic [31:0] rx_data;

    spi_xfer_ctrl #(.SPI_DIVIDER_LEN(8), .SPI_MAX_CHAR(32)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort),
        .char_len(char_len), .lsb(lsb), .tx_negedge(tx_negedge),
        .rx_negedge(rx_negedge), .div_in(div_in), .tx_data(tx_data),
        .miso(miso), .cg_pos_edge(cg_pos_edge), .cg_neg_edge(cg_neg_edge),
        .cg_enable(cg_enable), .cg_go(cg_go), .cg_last_clk(cg_last_clk),
        .cg_divider(cg_divider), .mosi(mosi), .rx_data(rx_data),
        .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock generator model: after go rises, strobes every divider+1
    // cycles, neg_edge first, then alternating.
    logic loop_en, ext_miso;
    int   cg_dcnt;
    bit   cg_phase, cg_first;
    initial begin
        cg_pos_edge = 1'b0; cg_neg_edge = 1'b0; miso = 1'b0;
        cg_first = 1'b1; cg_phase = 1'b0; cg_dcnt = 0;
        forever begin
            @(posedge clk_in); #1;
            cg_pos_edge = 1'b0; cg_neg_edge = 1'b0;
            if (!cg_go) begin
                cg_first = 1'b1; cg_phase = 1'b0;
            end else if (cg_first) begin
                cg_first = 1'b0; cg_dcnt = int'(cg_divider);
            end else if (cg_dcnt == 0) begin
                if (cg_phase == 1'b0) cg_neg_edge = 1'b1;
                else                  cg_pos_edge = 1'b1;
                cg_phase = ~cg_phase;
                cg_dcnt  = int'(cg_divider);
            end else begin
                cg_dcnt--;
            end
            miso = loop_en ? mosi : ext_miso;
        end
    end

    // Reference model: a transfer is "bit k of len in the chosen order";
    // k counts received bits, and a transmit shows bit k before it advances.
    int          m_ph = 0;  // 0 idle, 1 transferring, 2 completion cycle
    int          m_len = 0, m_krx = 0;
    bit          m_lsb, m_txn, m_rxn, m_txfire, txe, rxe;
    logic [31:0] m_word, m_acc;
    logic        e_busy = 0, e_done = 0, e_mosi = 0, e_go = 0, e_last = 0;
    logic [31:0] e_rx = '0;
    logic [7:0]  e_div = '0;

    function automatic int bitpos(input int k);
        return m_lsb ? k : (m_len - 1 - k);
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        m_txfire = 1'b0;
        if (!rst_n) begin
            m_ph = 0; m_krx = 0; m_len = 0;
            e_busy = 0; e_done = 0; e_mosi = 0; e_rx = '0; e_div = '0;
        end else begin
            case (m_ph)
                0: begin
                    e_done = 0;
                    if (start) begin
                        m_ph   = 1; e_busy = 1;
                        m_len  = (char_len == 5'd0) ? 32 : int'(char_len);
                        m_lsb  = lsb; m_txn = tx_negedge; m_rxn = rx_negedge;
                        m_word = tx_data; m_acc = '0; m_krx = 0; e_div = div_in;
                    end
                end
                1: begin
                    if (abort) begin
                        m_ph = 0; e_busy = 0;
                    end else begin
                        txe = m_txn ? cg_neg_edge : cg_pos_edge;
                        rxe = m_rxn ? cg_neg_edge : cg_pos_edge;
                        if (txe) begin
                            e_mosi = m_word[bitpos(m_krx)];
                            m_txfire = 1'b1;
                        end
                        if (rxe) begin
                            m_acc[bitpos(m_krx)] = miso;
                            m_krx++;
                            if (m_krx == m_len) begin
                                m_ph = 2; e_done = 1; e_rx = m_acc;
                            end
                        end
                    end
                end
                default: begin
                    m_ph = 0; e_done = 0; e_busy = 0;
                end
            endcase
        end
        e_go   = (m_ph == 1);
        e_last = (m_ph == 1) && (m_len - m_krx == 1);
    end

    // Per-cycle compare plus event counters used by the directed checks.
    int   done_cnt = 0, last_cnt = 0, go_cnt = 0, rx_cnt = 0;
    logic cap[$];
    always @(negedge clk_in) begin
        check("busy",        32'(busy),        32'(e_busy));
        check("done",        32'(done),        32'(e_done));
        check("mosi",        32'(mosi),        32'(e_mosi));
        check("rx_data",     rx_data,          e_rx);
        check("cg_enable",   32'(cg_enable),   32'(e_busy));
        check("cg_go",       32'(cg_go),       32'(e_go));
        check("cg_last_clk", 32'(cg_last_clk), 32'(e_last));
        check("cg_divider",  32'(cg_divider),  32'(e_div));
        if (m_txfire) cap.push_back(mosi);
        if (done) done_cnt++;
        if (cg_last_clk) last_cnt++;
        if (cg_go) go_cnt++;
        if (cg_go && (rx_negedge ? cg_neg_edge : cg_pos_edge)) rx_cnt++;
    end

    task automatic clear_counters();
        done_cnt = 0; last_cnt = 0; go_cnt = 0; rx_cnt = 0;
        cap.delete();
    endtask

    task automatic start_xfer(input logic [4:0] cl, input logic l, input logic txn,
                              input logic rxn, input logic [7:0] dv,
                              input logic [31:0] d, input logic with_abort);
        @(posedge clk_in); #1;
        char_len = cl; lsb = l; tx_negedge = txn; rx_negedge = rxn;
        div_in = dv; tx_data = d; start = 1'b1; abort = with_abort;
        @(posedge clk_in); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk_in); n++;
        end while (busy && n < max_cyc);
        check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rx(input int cnt, input int max_cyc, input string name);
        int n = 0;
        while (rx_cnt < cnt && n < max_cyc) begin
            @(negedge clk_in); n++;
        end
        check({name, "_rx_wait"}, 32'(rx_cnt >= cnt), 32'd1);
    endtask

    logic [31:0] v;
    bit          hit;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; char_len = 0; lsb = 0;
        tx_negedge = 0; rx_negedge = 0; div_in = 0; tx_data = 0;
        loop_en = 1'b1; ext_miso = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_div",     32'(cg_divider), 32'd0);

        // 8-bit MSB-first loopback of 0xA5, divider 4
        clear_counters();
        start_xfer(5'd8, 1'b0, 1'b1, 1'b0, 8'd4, 32'hA5, 1'b0);
        wait_idle(400, "t1");
        v = '0;
        foreach (cap[i]) v = {v[30:0], cap[i]};
        check("t1_mosi_count",  32'(cap.size()), 32'd8);
        check("t1_mosi_serial", v, 32'hA5);
        check("t1_rx_data",     rx_data, 32'h0000_00A5);
        check("t1_done_pulses", 32'(done_cnt), 32'd1);
        check("t1_last_clk_cyc", 32'(last_cnt), 32'd10);

        // 32-bit LSB-first loopback, char_len 0
        clear_counters();
        start_xfer(5'd0, 1'b1, 1'b1, 1'b0, 8'd1, 32'h8000_0001, 1'b0);
        wait_idle(800, "t2");
        check("t2_rx_edges",  32'(rx_cnt), 32'd32);
        check("t2_rx_data",   rx_data, 32'h8000_0001);
        check("t2_first_mosi", (cap.size() > 0) ? 32'(cap[0]) : 32'hFFFF_FFFF, 32'd1);
        check("t2_done_pulses", 32'(done_cnt), 32'd1);

        // start held during RUN with reconfigured inputs: ignored
        clear_counters();
        start_xfer(5'd8, 1'b0, 1'b0, 1'b0, 8'd2, 32'h3C, 1'b0);
        @(posedge clk_in); #1;
        start = 1'b1; char_len = 5'd3; lsb = 1'b1; div_in = 8'd9;
        tx_data = 32'hFFFF_FFFF; tx_negedge = 1'b1;
        repeat (20) @(posedge clk_in);
        #1 start = 1'b0;
        wait_idle(400, "t3");
        check("t3_done_pulses", 32'(done_cnt), 32'd1);
        check("t3_rx_data", rx_data, 32'h0000_009E);
        clear_counters();
        start_xfer(5'd8, 1'b1, 1'b1, 1'b0, 8'd1, 32'h0F, 1'b0);
        @(negedge clk_in);
        check("t3_restart_busy", 32'(busy), 32'd1);
        wait_idle(400, "t3b");
        check("t3_restart_rx", rx_data, 32'h0000_000F);
        check("t3_restart_done", 32'(done_cnt), 32'd1);

        // abort after three received bits
        clear_counters();
        start_xfer(5'd8, 1'b0, 1'b1, 1'b0, 8'd4, 32'hC3, 1'b0);
        wait_rx(3, 300, "t4");
        @(posedge clk_in); #1 abort = 1'b1;
        @(posedge clk_in); #1 abort = 1'b0;
        @(negedge clk_in);
        check("t4_busy",  32'(busy), 32'd0);
        check("t4_go",    32'(cg_go), 32'd0);
        check("t4_rx_held", rx_data, 32'h0000_000F);
        repeat (5) @(negedge clk_in);
        check("t4_no_done", 32'(done_cnt), 32'd0);

        // abort coincident with start in IDLE has no effect
        clear_counters();
        start_xfer(5'd8, 1'b0, 1'b0, 1'b1, 8'd0, 32'h5A, 1'b1);
        @(negedge clk_in);
        check("t4_idle_abort_busy", 32'(busy), 32'd1);
        wait_idle(200, "t4b");
        check("t4_idle_abort_done", 32'(done_cnt), 32'd1);

        // single-bit transfer, divider 1, miso tied high
        loop_en = 1'b0; ext_miso = 1'b1;
        clear_counters();
        start_xfer(5'd1, 1'b0, 1'b1, 1'b0, 8'd1, 32'h0, 1'b0);
        wait_idle(100, "t5");
        check("t5_run_cycles",  32'(go_cnt), 32'd5);
        check("t5_last_cycles", 32'(last_cnt), 32'd5);
        check("t5_rx_data",     rx_data, 32'h0000_0001);
        check("t5_done_pulses", 32'(done_cnt), 32'd1);

        // abort on the same cycle as the final rx edge
        ext_miso = 1'b0;
        clear_counters();
        start_xfer(5'd1, 1'b0, 1'b1, 1'b0, 8'd1, 32'h0, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            @(posedge clk_in); #2;
            if (cg_go && cg_pos_edge) hit = 1'b1;
        end
        check("t6_final_edge_seen", 32'(hit), 32'd1);
        abort = 1'b1;
        @(posedge clk_in); #1 abort = 1'b0;
        @(negedge clk_in);
        check("t6_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_in);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_rx_held", rx_data, 32'h0000_0001);

        // asynchronous reset mid-transfer
        loop_en = 1'b1;
        clear_counters();
        start_xfer(5'd8, 1'b0, 1'b1, 1'b0, 8'd4, 32'hFF, 1'b0);
        wait_rx(2, 300, "t7");
        @(posedge clk_in); #3 rst_n = 1'b0;
        #1;
        check("t7_busy",      32'(busy), 32'd0);
        check("t7_done",      32'(done), 32'd0);
        check("t7_mosi",      32'(mosi), 32'd0);
        check("t7_rx_data",   rx_data, 32'd0);
        check("t7_cg_go",     32'(cg_go), 32'd0);
        check("t7_cg_enable", 32'(cg_enable), 32'd0);
        check("t7_cg_last",   32'(cg_last_clk), 32'd0);
        check("t7_cg_div",    32'(cg_divider), 32'd0);
        @(posedge clk_in); @(posedge clk_in);
        #3 rst_n = 1'b1;
        repeat (40) @(negedge clk_in);
        check("t7_no_done", 32'(done_cnt), 32'd0);
        check("t7_idle",    32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
